// File: rtl/io_sequence_checker.sv
// Synchronises an observed I/O bus and steps it through a programmable table
// of masked expected values, reporting pass/fail, progress and failure cause.
module io_sequence_checker #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_W   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
    input  logic [WIDTH-1:0]           cfg_data_i,
    input  logic [WIDTH-1:0]           cfg_mask_i,
    input  logic [$clog2(DEPTH):0]     seq_len_i,
    input  logic [TIMEOUT_W-1:0]       timeout_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [WIDTH-1:0]           sample_i,
    output logic                       busy_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic [1:0]                 fail_code_o,
    output logic [$clog2(DEPTH):0]     step_o,
    output logic                       match_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    logic [SW-1:0]        len_q, len_d;
    logic [SW-1:0]        step_q, step_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [1:0]           code_q, code_d;
    logic                 match_q, match_d;

    logic [WIDTH-1:0] sampled;
    logic [AW-1:0]    idx;
    logic [SW-1:0]    step_nxt;
    logic             hit;
    logic             tmo_hit;

    // Table is deliberately left unreset; it is only meaningful once written.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we_i && state_q != RUN) begin
            data_mem[cfg_addr_i] <= cfg_data_i;
            mask_mem[cfg_addr_i] <= cfg_mask_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sample_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sampled  = sync_q[SYNC_STAGES-1];
    assign idx      = step_q[AW-1:0];
    assign step_nxt = step_q + SW'(1);
    assign hit      = ((sampled ^ data_mem[idx]) & mask_mem[idx]) == '0;
    assign tmo_hit  = (tmo_q != '0) && (cnt_q == tmo_q - TIMEOUT_W'(1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;
        match_d = 1'b0;
        unique case (state_q)
            RUN: begin
                busy_d = 1'b1;
                if (abort_i) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                    code_d  = 2'b10;
                end else if (hit) begin
                    step_d  = step_nxt;
                    match_d = 1'b1;
                    cnt_d   = '0;
                    if (step_nxt == len_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        pass_d  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    fail_d  = 1'b1;
                    code_d  = 2'b01;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            IDLE, DONE: begin
                if (start_i) begin
                    len_d  = seq_len_i;
                    tmo_d  = timeout_i;
                    cnt_d  = '0;
                    step_d = '0;
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                    code_d = 2'b00;
                    if (seq_len_i == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= 2'b00;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            match_q <= match_d;
        end
    end

    assign busy_o      = busy_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign fail_code_o = code_q;
    assign step_o      = step_q;
    assign match_o     = match_q;

endmodule

// File: tb/tb_io_sequence_checker.sv
// Directed bench for io_sequence_checker with a cycle-level reference model
// and per-cycle output comparison.
module tb_io_sequence_checker;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
    logic [4:0] seq_len;
    logic [15:0] tmo;
    logic       start;
    logic       abort;
    logic [7:0] sample;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] code;
    logic [4:0] step;
    logic       match;

    io_sequence_checker #(
        .WIDTH(8), .DEPTH(16), .TIMEOUT_W(16), .SYNC_STAGES(2)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we_i(we),
        .cfg_addr_i(addr), .cfg_data_i(data), .cfg_mask_i(mask),
        .seq_len_i(seq_len), .timeout_i(tmo), .start_i(start),
        .abort_i(abort), .sample_i(sample), .busy_o(busy),
        .pass_o(pass), .fail_o(fail), .fail_code_o(code),
        .step_o(step), .match_o(match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dut_matches = 0;
    bit chk_en = 0;

    logic [7:0] vals [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};

    // reference model state
    int m_data [16];
    int m_mask [16];
    logic [7:0] m_hist [2];
    bit m_busy, m_pass, m_fail, m_match;
    int m_code, m_step, m_cnt, m_len, m_tmo;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    initial begin
        bit was_busy;
        logic [7:0] s;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_busy = 0; m_pass = 0; m_fail = 0; m_match = 0;
                m_code = 0; m_step = 0; m_cnt = 0; m_len = 0; m_tmo = 0;
                m_hist[0] = 8'h00; m_hist[1] = 8'h00;
            end else begin
                was_busy = m_busy;
                s = m_hist[1];
                m_match = 0;
                if (m_busy) begin
                    if (abort) begin
                        m_busy = 0; m_fail = 1; m_code = 2;
                    end else if (((s ^ m_data[m_step]) & m_mask[m_step]) == 0) begin
                        m_step++; m_match = 1; m_cnt = 0;
                        if (m_step == m_len) begin
                            m_busy = 0; m_pass = 1;
                        end
                    end else if (m_tmo != 0 && m_cnt == m_tmo - 1) begin
                        m_busy = 0; m_fail = 1; m_code = 1;
                    end else if (m_cnt < 65535) begin
                        m_cnt++;
                    end
                end else if (start) begin
                    m_len = int'(seq_len); m_tmo = int'(tmo);
                    m_pass = 0; m_fail = 0; m_code = 0; m_step = 0; m_cnt = 0;
                    if (m_len == 0) m_pass = 1;
                    else m_busy = 1;
                end
                if (we && !was_busy) begin
                    m_data[addr] = int'(data);
                    m_mask[addr] = int'(mask);
                end
                m_hist[1] = m_hist[0];
                m_hist[0] = sample;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy", busy, m_busy);
                chk("pass", pass, m_pass);
                chk("fail", fail, m_fail);
                chk("code", code, m_code);
                chk("step", step, m_step);
                chk("match", match, m_match);
                if (pass === 1'b1 && fail === 1'b1) chk("pass_and_fail", 1, 0);
                if (match === 1'b1) dut_matches++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [7:0] d,
                               input logic [7:0] m);
        we = 1; addr = 4'(a); data = d; mask = m;
        tick();
        we = 0;
    endtask

    task automatic start_run(input int len, input int t);
        seq_len = 5'(len); tmo = 16'(t); start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_seq(input string tag);
        sample = 8'h00;
        repeat (3) tick();
        dut_matches = 0;
        start_run(12, 0);
        for (int i = 0; i < 12; i++) begin
            sample = vals[i];
            repeat (4) tick();
        end
        repeat (4) tick();
        chk({tag, "_pass"}, pass, 1);
        chk({tag, "_step"}, step, 12);
        chk({tag, "_matches"}, dut_matches, 12);
    endtask

    initial begin
        int t_match;
        int t_fail;
        int k;
        rst = 1; we = 0; addr = 0; data = 0; mask = 0; seq_len = 0;
        tmo = 0; start = 0; abort = 0; sample = 0;
        tick(); tick();
        rst = 0;
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_step", step, 0);

        for (int i = 0; i < 12; i++) write_entry(i, vals[i], 8'hFF);

        // full sequence, no timeout
        run_seq("seq");

        // stall after entry 3 with timeout 100
        sample = 8'h00;
        repeat (3) tick();
        start_run(12, 100);
        t_match = -1;
        t_fail = -1;
        for (int i = 0; i < 4; i++) begin
            sample = vals[i];
            repeat (4) begin
                tick();
                if (match && step == 5'd4) t_match = cyc;
            end
        end
        sample = 8'hA5;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (fail) begin
                t_fail = cyc;
                break;
            end
        end
        chk("tmo_fail", fail, 1);
        chk("tmo_code", code, 2'b01);
        chk("tmo_step", step, 4);
        chk("tmo_delay", t_fail - t_match, 100);

        // masked compare and latency
        write_entry(0, 8'h03, 8'h0F);
        sample = 8'h00;
        repeat (3) tick();
        start_run(1, 0);
        repeat (3) tick();
        sample = 8'hA3;
        k = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (match) begin
                k = n;
                break;
            end
        end
        chk("mask_latency", k, 3);
        chk("mask_pass", pass, 1);
        write_entry(0, 8'h01, 8'hFF);

        // zero-length run
        dut_matches = 0;
        start_run(0, 0);
        chk("len0_pass", pass, 1);
        chk("len0_busy", busy, 0);
        chk("len0_match", dut_matches, 0);

        // abort at step 2, with an ignored write in between
        sample = 8'h00;
        repeat (3) tick();
        start_run(12, 0);
        for (int i = 0; i < 2; i++) begin
            sample = vals[i];
            repeat (4) tick();
        end
        write_entry(5, 8'h77, 8'hFF);
        abort = 1;
        tick();
        abort = 0;
        chk("abort_fail", fail, 1);
        chk("abort_code", code, 2'b10);
        chk("abort_step", step, 2);
        run_seq("readback");

        // reset mid-run, then restart
        sample = 8'h00;
        repeat (3) tick();
        start_run(12, 0);
        for (int i = 0; i < 3; i++) begin
            sample = vals[i];
            repeat (4) tick();
        end
        rst = 1;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_step", step, 0);
        chk("midrst_fail", fail, 0);
        rst = 0;
        run_seq("restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
